// File: rtl/gray_sync_decoder_if.sv
// Gray-count receive bus: remote Gray count and error clear in, decoded count and status out.
interface gray_sync_decoder_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] gray_in;
    logic             clr_err;
    logic [WIDTH-1:0] binary_out;
    logic             valid;
    logic [WIDTH-1:0] delta;
    logic             step_err;
    logic [7:0]       err_count;
    logic             locked;

    modport master (
        output gray_in, clr_err,
        input  binary_out, valid, delta, step_err, err_count, locked
    );

    modport slave (
        input  gray_in, clr_err,
        output binary_out, valid, delta, step_err, err_count, locked
    );
endinterface

// File: rtl/gray_sync_decoder.sv
// Synchronizes a remote Gray count into clk, decodes to binary, flags multi-bit steps; SYNC_STAGES+1 edges in to out, no backpressure.
// GRAY_SYNC_DEC_FILTER_EN: when defined, binary_out holds its last accepted value across a multi-bit error.
module gray_sync_decoder #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CNT    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gray_sync_decoder_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_ACQ     = 2'd0,
        ST_LOCKING = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  r_prev;
    logic [WIDTH-1:0]                  r_bin;
    logic [WIDTH-1:0]                  r_delta;
    logic                              r_valid;
    logic                              r_step_err;
    logic [7:0]                        r_err_count;
    state_t                            r_state;
    logic [2:0]                        r_acq_cnt;
    logic [3:0]                        r_lock_cnt;

    logic [WIDTH-1:0]                  w_s_q;
    logic [WIDTH-1:0]                  w_dec;
    logic [WIDTH-1:0]                  w_diff;
    logic                              w_multi;
    logic                              w_one;
    logic                              w_active;
    logic                              w_capture;
    state_t                            w_state_nxt;
    logic [2:0]                        w_acq_nxt;
    logic [3:0]                        w_lock_nxt;

    // Plain flop chain: nothing but s_q leaves the synchronizer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.gray_in};
        end
    end

    assign w_s_q = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_dec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_dec[i] = ^(w_s_q >> i);
        end
    end

    // x & (x-1) is non-zero exactly when more than one bit is set.
    assign w_diff   = w_s_q ^ r_prev;
    assign w_multi  = |(w_diff & (w_diff - WIDTH'(1)));
    assign w_one    = (w_diff != '0) && !w_multi;
    assign w_active = (r_state != ST_ACQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_ACQ;
            r_acq_cnt  <= '0;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_acq_cnt  <= w_acq_nxt;
            r_lock_cnt <= w_lock_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acq_nxt   = r_acq_cnt;
        w_lock_nxt  = r_lock_cnt;
        w_capture   = 1'b0;
        case (r_state)
            ST_ACQ: begin
                if (r_acq_cnt == 3'(SYNC_STAGES)) begin
                    w_capture   = 1'b1;
                    w_lock_nxt  = '0;
                    w_state_nxt = ST_LOCKING;
                end else begin
                    w_acq_nxt = r_acq_cnt + 3'd1;
                end
            end
            ST_LOCKING: begin
                if (w_multi) begin
                    w_lock_nxt = '0;
                end else begin
                    w_lock_nxt = r_lock_cnt + 4'd1;
                    if (r_lock_cnt + 4'd1 == 4'(LOCK_CNT)) begin
                        w_state_nxt = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_multi) begin
                    w_lock_nxt  = '0;
                    w_state_nxt = ST_LOCKING;
                end
            end
            default: begin
                w_state_nxt = ST_ACQ;
                w_acq_nxt   = '0;
                w_lock_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev     <= '0;
            r_bin      <= '0;
            r_delta    <= '0;
            r_valid    <= 1'b0;
            r_step_err <= 1'b0;
        end else begin
            r_valid    <= 1'b0;
            r_step_err <= 1'b0;
            if (w_capture) begin
                // First sample after acquisition is only a reference.
                r_prev  <= w_s_q;
                r_bin   <= w_dec;
                r_delta <= '0;
            end else if (w_active) begin
                r_prev <= w_s_q;
                if (w_one) begin
                    r_valid <= 1'b1;
                    r_bin   <= w_dec;
                    r_delta <= w_dec - r_bin;
                end else if (w_multi) begin
                    r_step_err <= 1'b1;
                    r_delta    <= '0;
`ifdef GRAY_SYNC_DEC_FILTER_EN
                    r_bin      <= r_bin;
`else
                    r_bin      <= w_dec;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (w_active && w_multi) begin
            if (bus.clr_err) begin
                r_err_count <= 8'd1;
            end else if (r_err_count != 8'hFF) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end else if (bus.clr_err) begin
            r_err_count <= '0;
        end
    end

    assign bus.binary_out = r_bin;
    assign bus.valid      = r_valid;
    assign bus.delta      = r_delta;
    assign bus.step_err   = r_step_err;
    assign bus.err_count  = r_err_count;
    assign bus.locked     = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Directed bench for gray_sync_decoder: inputs change and outputs are sampled on the falling edge.
module tb_gray_sync_decoder;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   valid_seen;
    int   err_seen;
    int   v_base;
    int   e_base;

    gray_sync_decoder_if #(.WIDTH(8)) bus ();

    gray_sync_decoder #(
        .WIDTH      (8),
        .SYNC_STAGES(2),
        .LOCK_CNT   (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        valid_seen = 0;
        err_seen   = 0;
    end

    always @(negedge clk) begin
        if (bus.valid === 1'b1)    valid_seen = valid_seen + 1;
        if (bus.step_err === 1'b1) err_seen   = err_seen + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One clean Gray step: nothing visible after 2 edges, result after the 3rd.
    task automatic step(input logic [7:0] g, input logic [7:0] eb, input logic [7:0] ed, input string tag);
        bus.gray_in = g;
        tick(2);
        chk({tag, "_early_valid"}, 32'(bus.valid), 32'd0);
        tick(1);
        chk({tag, "_bin"}, 32'(bus.binary_out), 32'(eb));
        chk({tag, "_delta"}, 32'(bus.delta), 32'(ed));
        chk({tag, "_valid"}, 32'(bus.valid), 32'd1);
        tick(1);
        chk({tag, "_valid_drop"}, 32'(bus.valid), 32'd0);
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        rst_n       = 1'b0;
        bus.gray_in = 8'h00;
        bus.clr_err = 1'b0;
        tick(2);

        chk("rst_bin", 32'(bus.binary_out), 32'd0);
        chk("rst_delta", 32'(bus.delta), 32'd0);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_step_err", 32'(bus.step_err), 32'd0);
        chk("rst_err_count", 32'(bus.err_count), 32'd0);
        chk("rst_locked", 32'(bus.locked), 32'd0);

        // Acquisition with a static input, then lock after 4 idle cycles.
        rst_n = 1'b1;
        tick(3);
        chk("acq_bin", 32'(bus.binary_out), 32'd0);
        chk("acq_locked", 32'(bus.locked), 32'd0);
        tick(3);
        chk("lock_early", 32'(bus.locked), 32'd0);
        tick(1);
        chk("lock_set", 32'(bus.locked), 32'd1);
        chk("acq_no_valid", 32'(valid_seen), 32'd0);

        // Up-counting sequence.
        v_base = valid_seen;
        step(8'h01, 8'd1, 8'd1, "up1");
        step(8'h03, 8'd2, 8'd1, "up2");
        step(8'h02, 8'd3, 8'd1, "up3");
        chk("up_valid_count", 32'(valid_seen - v_base), 32'd3);

        // Walk to 0x80 one bit at a time, then wrap both ways.
        step(8'h82, 8'hFC, 8'd249, "to82");
        step(8'h80, 8'hFF, 8'd3,   "to80");
        step(8'h00, 8'h00, 8'd1,   "wrap_up");
        step(8'h80, 8'hFF, 8'hFF,  "wrap_dn");
        step(8'h00, 8'h00, 8'd1,   "back0");
        step(8'h01, 8'd1, 8'd1,    "re1");
        step(8'h03, 8'd2, 8'd1,    "re2");
        step(8'h02, 8'd3, 8'd1,    "re3");
        chk("locked_before_jump", 32'(bus.locked), 32'd1);

        // Three-bit jump while locked.
        bus.gray_in = 8'h05;
        tick(3);
        chk("jump_step_err", 32'(bus.step_err), 32'd1);
        chk("jump_err_count", 32'(bus.err_count), 32'd1);
        chk("jump_locked", 32'(bus.locked), 32'd0);
        chk("jump_delta", 32'(bus.delta), 32'd0);
        chk("jump_valid", 32'(bus.valid), 32'd0);
`ifdef GRAY_SYNC_DEC_FILTER_EN
        chk("jump_bin", 32'(bus.binary_out), 32'd3);
`else
        chk("jump_bin", 32'(bus.binary_out), 32'd6);
`endif
        tick(1);
        chk("jump_pulse_drop", 32'(bus.step_err), 32'd0);
        tick(2);
        chk("relock_early", 32'(bus.locked), 32'd0);
        tick(1);
        chk("relock_set", 32'(bus.locked), 32'd1);
`ifdef GRAY_SYNC_DEC_FILTER_EN
        step(8'h04, 8'd7, 8'd4, "after_jump");
`else
        step(8'h04, 8'd7, 8'd1, "after_jump");
`endif

        // Continuous 3-bit toggling drives the error counter into saturation.
        for (int i = 0; i < 260; i++) begin
            bus.gray_in = (i % 2 == 0) ? 8'h03 : 8'h04;
            tick(1);
        end
        tick(4);
        chk("sat_err_count", 32'(bus.err_count), 32'd255);
        chk("sat_step_err_idle", 32'(bus.step_err), 32'd0);

        // Clear coinciding with an error leaves a count of one.
        bus.gray_in = 8'h03;
        tick(2);
        bus.clr_err = 1'b1;
        tick(1);
        bus.clr_err = 1'b0;
        chk("clr_with_err_pulse", 32'(bus.step_err), 32'd1);
        chk("clr_with_err_count", 32'(bus.err_count), 32'd1);
        bus.clr_err = 1'b1;
        tick(1);
        bus.clr_err = 1'b0;
        chk("clr_alone_count", 32'(bus.err_count), 32'd0);

        // Walk to binary 0x40, then reset mid-operation.
        step(8'h02, 8'd3,  8'd1,   "w1");
        step(8'h00, 8'd0,  8'd253, "w2");
        step(8'h20, 8'h3F, 8'd63,  "w3");
        step(8'h60, 8'h40, 8'd1,   "w4");
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_bin", 32'(bus.binary_out), 32'd0);
        chk("mid_rst_delta", 32'(bus.delta), 32'd0);
        chk("mid_rst_locked", 32'(bus.locked), 32'd0);
        chk("mid_rst_err_count", 32'(bus.err_count), 32'd0);
        tick(1);
        rst_n  = 1'b1;
        e_base = err_seen;
        tick(3);
        chk("reacq_bin", 32'(bus.binary_out), 32'h40);
        chk("reacq_delta", 32'(bus.delta), 32'd0);
        chk("reacq_valid", 32'(bus.valid), 32'd0);
        tick(4);
        chk("reacq_locked", 32'(bus.locked), 32'd1);
        chk("reacq_no_step_err", 32'(err_seen - e_base), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
